reset_conditioner: RTL and testbench

Conditions the raw board reset pushbutton into a clean, stretched, active-low reset for the CPU clock divider and the CPU core. Sits directly upstream of the CPU clock generator, whose reset input is active-low; this block drives that input.
- Synchronises the asynchronous button.
- Debounces it.
- Holds the reset asserted while the button is held.
- Stretches the release by a fixed number of sysclk cycles, so the divider and core leave reset cleanly.

---
 rtl/reset_conditioner.sv | 129 ++++++++++++
 tb/tb_reset_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_conditioner.sv
// Turns the raw reset pushbutton into a synchronised, debounced, release-stretched active-low reset.
// Optional: define RST_COUNT_EN to add the saturating reset_count output.
module reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 256,
  parameter int CNT_W           = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       rst_n_out,
  output logic       busy
`ifdef RST_COUNT_EN
  ,
  output logic [7:0] reset_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_ASSERT   = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_n_q, rst_n_d;
  logic                   busy_q, busy_d;

  assign btn_s     = sync_q[SYNC_STAGES-1];
  assign rst_n_out = rst_n_q;
  assign busy      = busy_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // State, counter and output flops; outputs are registered from next-state values.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (btn_s) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!btn_s) begin
          state_d = ST_RUN;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_ASSERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ASSERT: begin
        if (!btn_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // A press during the stretch restarts it without needing a fresh debounce.
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rst_n_d = (state_d == ST_RUN) || (state_d == ST_DEBOUNCE);
    busy_d  = (state_d != ST_RUN);
  end

`ifdef RST_COUNT_EN
  logic [7:0] rcnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rcnt_q <= 8'd0;
    end else if (state_q == ST_DEBOUNCE && state_d == ST_ASSERT) begin
      rcnt_q <= sat_inc8(rcnt_q);
    end
  end

  assign reset_count = rcnt_q;
`endif

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed plus randomised bench for reset_conditioner, checked cycle by cycle
// against a run-length model of the button/reset rules.
module tb_reset_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic sysclk = 1'b0;
  logic reset;
  logic btn_raw;
  logic rst_n_out;
  logic busy;
`ifdef RST_COUNT_EN
  logic [7:0] reset_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference model state: synchroniser image plus run-length counters.
  logic [SYNC-1:0] m_sync;
  bit m_asserted;
  bit m_waiting;
  int m_hi_run;
  int m_quiet;
  int m_cnt;

  reset_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .CNT_W(16)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .btn_raw(btn_raw),
    .rst_n_out(rst_n_out),
    .busy(busy)
`ifdef RST_COUNT_EN
    ,
    .reset_count(reset_count)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit bs;
    bs = m_sync[SYNC-1];
    if (reset) begin
      m_sync     = '0;
      m_asserted = 1'b1;
      m_waiting  = 1'b0;
      m_quiet    = 0;
      m_hi_run   = 0;
      m_cnt      = 0;
    end else begin
      m_sync = {m_sync[SYNC-2:0], btn_raw};
      if (!m_asserted) begin
        if (bs) begin
          m_hi_run++;
          if (m_hi_run == DEB + 1) begin
            m_asserted = 1'b1;
            m_waiting  = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        end else begin
          m_hi_run = 0;
        end
      end else if (m_waiting) begin
        if (!bs) begin
          m_waiting = 1'b0;
          m_quiet   = 0;
        end
      end else if (bs) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == HOLD) begin
          m_asserted = 1'b0;
          m_hi_run   = 0;
        end
      end
    end
  endtask

  // One clock edge: advance the model, then compare all outputs just after the edge.
  task automatic step();
    @(posedge sysclk);
    model_edge();
    cycle++;
    #1;
    chk("rst_n_out", {31'd0, rst_n_out}, {31'd0, !m_asserted});
    chk("busy", {31'd0, busy}, {31'd0, (m_asserted || m_hi_run > 0)});
`ifdef RST_COUNT_EN
    chk("reset_count", {24'd0, reset_count}, m_cnt);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Counts edges until rst_n_out reaches lvl; returns max+1 if it never does.
  task automatic edges_until(input logic lvl, input int max, output int n);
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (rst_n_out === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic press();
    btn_raw = 1'b1;
    steps(9);
    btn_raw = 1'b0;
    steps(12);
  endtask

  initial begin
    int n;
    bit saw_busy;
    bit saw_low;

    reset   = 1'b1;
    btn_raw = 1'b0;
    m_sync  = '0;

    // Power-on
    steps(3);
    reset = 1'b0;
    edges_until(1'b1, 20, n);
    chk("poweron_release_edges", n, HOLD);
    chk("poweron_busy_low", {31'd0, busy}, 32'd0);
    steps(3);

    // Glitch rejection
    btn_raw  = 1'b1;
    saw_busy = 1'b0;
    saw_low  = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) btn_raw = 1'b0;
      step();
      if (busy === 1'b1) saw_busy = 1'b1;
      if (rst_n_out !== 1'b1) saw_low = 1'b1;
    end
    chk("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    chk("glitch_no_reset", {31'd0, saw_low}, 32'd0);
    chk("glitch_busy_back", {31'd0, busy}, 32'd0);

    // Valid press held 20 cycles
    btn_raw = 1'b1;
    edges_until(1'b0, 20, n);
    chk("press_assert_edges", n, SYNC + 1 + DEB);
    steps(20 - n);
    chk("press_held_low", {31'd0, rst_n_out}, 32'd0);
    btn_raw = 1'b0;
    edges_until(1'b1, 30, n);
    chk("release_edges", n, SYNC + 1 + HOLD);
    steps(3);

    // Re-press 4 cycles into HOLD restarts the stretch
    btn_raw = 1'b1;
    steps(10);
    btn_raw = 1'b0;
    steps(SYNC + 1 + 4);
    btn_raw = 1'b1;
    step();
    btn_raw = 1'b0;
    edges_until(1'b1, 30, n);
    chk("hold_restart_edges", n, SYNC + HOLD);
    steps(3);

    // Reset mid-DEBOUNCE (cnt==2)
    btn_raw = 1'b1;
    steps(SYNC + 3);
    chk("middeb_still_high", {31'd0, rst_n_out}, 32'd1);
    reset = 1'b1;
    step();
    chk("middeb_reset_low", {31'd0, rst_n_out}, 32'd0);
    reset   = 1'b0;
    btn_raw = 1'b0;
    edges_until(1'b1, 20, n);
    chk("middeb_release_edges", n, HOLD);
    steps(3);

    // Randomised levels, run lengths and occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      btn_raw = 1'($urandom_range(0, 1));
      len     = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        reset = ($urandom_range(0, 40) == 0);
        step();
      end
      reset = 1'b0;
    end
    btn_raw = 1'b0;
    steps(HOLD + SYNC + 4);

`ifdef RST_COUNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(HOLD + 2);
    chk("count_cleared", {24'd0, reset_count}, 32'd0);
    press();
    press();
    chk("count_two", {24'd0, reset_count}, 32'd2);
    for (int i = 0; i < 255; i++) press();
    chk("count_saturated", {24'd0, reset_count}, 32'd255);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("count_reset", {24'd0, reset_count}, 32'd0);
    steps(HOLD + 2);
`else
    press();
    chk("final_released", {31'd0, rst_n_out}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
